// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator fed by PC1: C/D rotation registers plus PC2 wiring,
// one subkey per valid/ready handshake. Optional abort input under `DES_KS_ABORT_EN.
module des_key_schedule #(
  parameter int unsigned HOLD_LAST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [55:0] key_in,
  input  logic        sk_ready,
`ifdef DES_KS_ABORT_EN
  input  logic        abort,
`endif
  output logic        sk_valid,
  output logic [47:0] sk,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // PC2 source positions in DES numbering (1 = MSB of C||D)
  localparam int unsigned PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state, state_nxt;
  logic [27:0] c_q, d_q, c_nxt, d_nxt;
  logic [3:0]  round_q, round_nxt;
  logic        dec_q, dec_nxt;
  logic        done_q, done_nxt;
  logic [55:0] cd;
  logic [47:0] pc2_out;
  logic        single;

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  // Forward step uses S[round+2], backward uses S[16-round]; both are 1 only at rounds 0, 7, 14.
  assign single = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      c_q     <= c_nxt;
      d_q     <= d_nxt;
      round_q <= round_nxt;
      dec_q   <= dec_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    c_nxt     = c_q;
    d_nxt     = d_q;
    round_nxt = round_q;
    dec_nxt   = dec_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          round_nxt = '0;
          dec_nxt   = decrypt;
          c_nxt     = decrypt ? key_in[55:28] : rotl(key_in[55:28], 1'b1);
          d_nxt     = decrypt ? key_in[27:0]  : rotl(key_in[27:0], 1'b1);
        end
      end
      RUN: begin
        if (sk_ready) begin
          if (round_q == 4'd15) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            round_nxt = round_q + 4'd1;
            c_nxt     = dec_q ? rotr(c_q, single) : rotl(c_q, single);
            d_nxt     = dec_q ? rotr(d_q, single) : rotl(d_q, single);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef DES_KS_ABORT_EN
    if (abort) begin
      state_nxt = IDLE;
      round_nxt = '0;
      c_nxt     = c_q;
      d_nxt     = d_q;
      dec_nxt   = dec_q;
      done_nxt  = 1'b0;
    end
`endif
  end

  assign cd = {c_q, d_q};

  always_comb begin
    pc2_out = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      pc2_out[47 - i] = cd[56 - PC2_TBL[i]];
    end
  end

  assign sk_valid = (state == RUN);
  assign busy     = (state == RUN);
  assign round    = round_q;
  assign done     = done_q;
  assign sk       = ((HOLD_LAST != 0) || (state == RUN)) ? pc2_out : '0;

endmodule
